// File: rtl/dct_pkg.sv
// Shared constants and lane packing helper for the DCT datapath stages.
package dct_pkg;

    localparam int CW        = 12;
    localparam int QW        = 8;
    localparam int RW        = 16;
    localparam int LANES     = 8;
    localparam int ROW_BITS  = 3;
    localparam int TBL_DEPTH = LANES * LANES;

    localparam int unsigned RECIP_SHIFT = 15;
    localparam int MW = CW + RW - RECIP_SHIFT;

    localparam logic [RW-1:0] RECIP_RESET = 16'h8000;
    localparam int unsigned   ROUND_BIAS  = 16384;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    // Lane i of a packed row sits at bit offset i*width.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/dct_qz_lane.sv
// One lane of the quantizer output stage: scale magnitude by reciprocal,
// round half away from zero, restore sign and saturate.
module dct_qz_lane
    import dct_pkg::*;
(
    input  logic          sign,
    input  logic [CW-1:0] mag,
    input  logic [RW-1:0] recip,
    output logic [QW-1:0] q
);

    localparam int PW = CW + RW;

    logic [PW-1:0] prod;
    logic [MW-1:0] m;

    // Rounding on the magnitude makes the signed result symmetric around zero.
    always_comb begin
        prod = PW'(mag) * PW'(recip);
        m    = MW'((prod + PW'(ROUND_BIAS)) >> RECIP_SHIFT);
        if (sign) begin
            q = (m > MW'(-SAT_MIN)) ? QW'(SAT_MIN) : ({QW{1'b0}} - m[QW-1:0]);
        end else begin
            q = (m > MW'(SAT_MAX)) ? QW'(SAT_MAX) : m[QW-1:0];
        end
    end

endmodule

// File: rtl/dct_quantizer.sv
// Two-stage row quantizer with programmable reciprocal table and valid/ready flow.
// Optional per-block nonzero lane counter enabled by DCT_QUANT_NZCOUNT_EN.
module dct_quantizer
    import dct_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW*LANES-1:0]   in_data,
    input  logic                  tbl_we,
    input  logic [5:0]            tbl_addr,
    input  logic [RW-1:0]         tbl_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QW*LANES-1:0]   out_data,
    output logic [ROW_BITS-1:0]   out_row,
    output logic                  out_last,
    output logic [15:0]           blk_count
`ifdef DCT_QUANT_NZCOUNT_EN
    ,
    output logic [6:0]            nz_count
`endif
);

    logic [RW-1:0]       tbl [TBL_DEPTH];
    logic [ROW_BITS-1:0] row_cnt;

    logic                s1_valid;
    logic [ROW_BITS-1:0] s1_row;
    logic                s1_sign  [LANES];
    logic [CW-1:0]       s1_mag   [LANES];
    logic [RW-1:0]       s1_recip [LANES];

    logic                in_sign  [LANES];
    logic [CW-1:0]       in_mag   [LANES];
    logic [QW-1:0]       lane_q   [LANES];
    logic [QW*LANES-1:0] q_row;

    logic advance;

    // Only a full, unconsumed output register holds the pipeline back.
    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CW-1:0] coef;
        assign coef       = in_data[lane_lsb(i, CW) +: CW];
        assign in_sign[i] = coef[CW-1];
        assign in_mag[i]  = coef[CW-1] ? (~coef + CW'(1)) : coef;

        dct_qz_lane u_lane (
            .sign  (s1_sign[i]),
            .mag   (s1_mag[i]),
            .recip (s1_recip[i]),
            .q     (lane_q[i])
        );

        assign q_row[lane_lsb(i, QW) +: QW] = lane_q[i];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int t = 0; t < TBL_DEPTH; t++) begin
                tbl[t] <= RECIP_RESET;
            end
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    // Stage 1 reads the table before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_row   <= '0;
            row_cnt  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_sign[i]  <= 1'b0;
                s1_mag[i]   <= '0;
                s1_recip[i] <= RECIP_RESET;
            end
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                row_cnt <= row_cnt + 1'b1;
                s1_row  <= row_cnt;
                for (int i = 0; i < LANES; i++) begin
                    s1_sign[i]  <= in_sign[i];
                    s1_mag[i]   <= in_mag[i];
                    s1_recip[i] <= tbl[{row_cnt, ROW_BITS'(i)}];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= q_row;
                out_row  <= s1_row;
                out_last <= (s1_row == ROW_BITS'(LANES - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            blk_count <= '0;
        end else if (out_valid && out_ready && out_last) begin
            blk_count <= blk_count + 16'd1;
        end
    end

`ifdef DCT_QUANT_NZCOUNT_EN
    logic [6:0] nz_pop;
    logic [6:0] nz_base;

    // The count includes the row currently held in the output register.
    always_comb begin
        nz_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            nz_pop = nz_pop + 7'(|lane_q[i]);
        end
        nz_base = (out_valid && out_ready && out_last) ? 7'd0 : nz_count;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            nz_count <= '0;
        end else if (advance && s1_valid) begin
            nz_count <= nz_base + nz_pop;
        end else begin
            nz_count <= nz_base;
        end
    end
`endif

endmodule

// File: doc/dct_quantizer.md
Name: dct_quantizer

Overview:
- Stage directly downstream of the second (column) 1-D DCT and its transpose buffers.
- Consumes one 96-bit row of eight 12-bit signed DCT coefficients per handshake and quantizes each coefficient with a programmable reciprocal table.
- Produces a 64-bit row of eight 8-bit signed quantized values, tagged with row index and end-of-block, for the output memory writer.
- Fully pipelined: 2-cycle latency, valid/ready backpressure on both sides.

Parameters:
- CW, 12, input coefficient width (signed).
- QW, 8, output quantized width (signed, saturating).
- RW, 16, reciprocal width (unsigned Q1.15).
- LANES, 8, coefficients per row (also rows per block).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-low reset
- in_valid  in  1  input row valid
- in_ready  out  1  block can accept a row this cycle
- in_data  in  96  lane i = column i at bits [12i+11:12i]
- tbl_we  in  1  reciprocal table write enable
- tbl_addr  in  6  table index = row*8 + col
- tbl_data  in  16  reciprocal = round(32768/Q), Q in 1..255
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts the row
- out_data  out  64  lane i at bits [8i+7:8i]
- out_row  out  3  row index 0..7 within the block
- out_last  out  1  high with row 7
- blk_count  out  16  completed blocks, wraps at 65535->0

Behaviour:
- Reset (reset==0 at a clk edge):
  - Pipeline valids cleared; out_valid=0; out_data=0; out_row=0; out_last=0.
  - Input row counter=0; blk_count=0; all 64 table entries = 32768 (Q=1).
  - Reset mid-block discards in-flight rows; the next accepted row is row 0.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall; both stages advance together when not stalled.
  - A row is accepted when in_valid & in_ready. out_data, out_row and out_last stay stable while stalled.
  - No combinational path from in_valid to out_valid. in_ready depends only on out_valid, out_ready and registers.
- Stage 1 (accept edge):
  - Register sign and magnitude |c| of each lane (|−2048| = 2048, 12-bit unsigned).
  - Register the 8 reciprocals for the current row, plus the row index.
  - Row counter increments per accepted row and wraps 7->0.
- Stage 2 (next advancing edge), per lane:
  - m = (|c|*recip + 16384) >> 15, computed in 28-bit unsigned (round half away from zero).
  - q = sign ? −m : m, saturated to [−128, 127].
  - out_valid=1; out_last = (row==7).
- Latency: an accepted row appears at out_valid 2 cycles later if not stalled. Throughput is 1 row/cycle.
- blk_count increments on the edge where a row with out_last is consumed (out_valid & out_ready).
- Table writes:
  - Applied at the clk edge when tbl_we=1.
  - Affect any row captured into stage 1 on a later edge. The row captured on the same edge uses the old value.
  - Writes are legal at any time.
- in_valid/in_data may change freely while in_ready=0. Nothing is captured.

Optional Feature:
- Macro DCT_QUANT_NZCOUNT_EN.
- When defined:
  - Adds output nz_count (7 bits), a running count of nonzero quantized lanes in the current block.
  - Valid with out_last; the count includes row 7.
  - The accumulator clears after the last row is consumed and on reset; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package dct_pkg:
  - Constants CW, QW, RW, LANES.
  - Reset reciprocal value 32768 and rounding constant 16384.
  - Saturation limits −128/127.
  - The row/lane packing helper (lane bit offsets) shared with the DCT and transpose stages.
- One sub-module dct_qz_lane: a single lane's stage-2 multiply/round/negate/saturate, instantiated LANES times.
- Table storage, row counter, handshake and blk_count stay in dct_quantizer.

Test Plan:
- Reset table, one row with lanes 0..7 = 100, −100, 127, 128, −128, −129, 0, 2047 -> out_data lanes 100, −100, 127, 127, −128, −128, 0, 127; out_row=0; out_valid exactly 2 cycles after accept.
- Write recip 2048 (Q=16) to addr 0..7, row 0 lanes = 24, −24, 23, −23, 8, 7, −2048, 0 -> 2, −2, 1, −1, 1, 0, −128, 0.
- 8 back-to-back rows, out_ready=1 -> out_row 0..7, out_last only on row 7, blk_count 0->1 after the 8th consume; a 9th row gives out_row=0.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after pipeline fills, out_data stable; after release, rows emerge in order with none dropped or duplicated.
- Assert reset after row 3 of a block -> out_valid=0 next cycle, blk_count=0, table back to 32768; the next row gets out_row=0.
- (DCT_QUANT_NZCOUNT_EN) block of 8 rows with exactly 5 nonzero quantized lanes in total -> nz_count=5 with out_last; the next block starts from 0.
